// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the address decoder/mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Read data returned while the default slave signals an error
    localparam logic [31:0] ERROR_DATA = 32'hDEAD_BEEF;

    // Default-slave two-cycle ERROR response sequencer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } ds_state_t;

    // NONSEQ and SEQ are the only transfer types that need a data-phase response
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers transfers to unmapped addresses with a two-cycle AHB ERROR response.
// Latency: outputs are a function of the state register only; the ERROR takes two data-phase cycles.
// Backpressure: only advances out of IDLE on HREADY=1; ERR1 inserts the single wait state itself.
// Ports: hclk/hresetn (async active-low); hready = muxed bus ready; htrans + unmapped from the
//        current address phase; ready/resp/rdata = this slave's data-phase response.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hready,
    input  logic [1:0]        htrans,
    input  logic              unmapped,
    output logic              ready,
    output logic              resp,
    output logic [DATA_W-1:0] rdata
);

    // ERROR_DATA zero-extended or truncated to the bus width
    localparam logic [DATA_W+31:0] ERR_EXT    = {{DATA_W{1'b0}}, ERROR_DATA};
    localparam logic [DATA_W-1:0]  ERR_DATA_W = ERR_EXT[DATA_W-1:0];

    ds_state_t state;
    ds_state_t state_nxt;
    logic      err_start;

    // A new active transfer to an unmapped address is accepted on this edge
    assign err_start = hready && unmapped && trans_active(htrans);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        resp      = HRESP_OKAY;
        rdata     = '0;
        case (state)
            IDLE: begin
                if (err_start) begin
                    state_nxt = ERR1;
                end
            end
            ERR1: begin
                ready     = 1'b0;
                resp      = HRESP_ERROR;
                rdata     = ERR_DATA_W;
                state_nxt = ERR2;
            end
            ERR2: begin
                resp      = HRESP_ERROR;
                rdata     = ERR_DATA_W;
                // A pipelined unmapped transfer goes straight into the next ERROR
                state_nxt = err_start ? ERR1 : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and slave response multiplexer with optional default slave.
// Latency: HSEL is combinational from HADDR; responses are muxed with zero added latency.
// Backpressure: data-phase select (and default slave) advance only on HREADY=1; stalls freeze them.
// Ports: HCLK/HRESETn (async active-low); HADDR/HTRANS address phase in; HSEL_SIGNALS one-hot out;
//        HREADYOUT/HRESP/HRDATA_SIGNALS per-slave in; HREADY/HRESP/HRDATA muxed out.
// Build option: define AHB_DECODE_DEFAULT_SLAVE_EN to add the ERROR-returning default slave;
//        without it unmapped addresses alias to slave 0.
module ahb_decode_mux
    import ahb_pkg::*;
#(
    parameter int                            NUM_SLAVES = 3,
    parameter int                            DATA_W     = 32,
    parameter logic [NUM_SLAVES-1:0][31:0]   SLAVE_BASE = {32'h5000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES-1:0][31:0]   SLAVE_MASK = {32'hF000_0000, 32'hF000_0000, 32'hC000_0000}
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL_SIGNALS,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_SIGNALS,
    input  logic [NUM_SLAVES-1:0]        HRESP_SIGNALS,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_SIGNALS,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [DATA_W-1:0]            HRDATA
);

    logic [NUM_SLAVES-1:0] hit;
    logic                  unmapped;
    logic                  def_sel;
    logic                  ds_ready;
    logic                  ds_resp;
    logic [DATA_W-1:0]     ds_rdata;

    // Data-phase select: one bit per slave plus the default slave in the top bit
    logic [NUM_SLAVES:0]   dsel;

    // Address decode; the first (lowest-index) matching region wins on overlap
    always_comb begin
        hit      = '0;
        unmapped = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (unmapped && ((HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
                hit[i]   = 1'b1;
                unmapped = 1'b0;
            end
        end
    end

`ifdef AHB_DECODE_DEFAULT_SLAVE_EN
    assign HSEL_SIGNALS = hit;
    assign def_sel      = unmapped;

    ahb_default_slave #(
        .DATA_W (DATA_W)
    ) u_default_slave (
        .hclk     (HCLK),
        .hresetn  (HRESETn),
        .hready   (HREADY),
        .htrans   (HTRANS),
        .unmapped (unmapped),
        .ready    (ds_ready),
        .resp     (ds_resp),
        .rdata    (ds_rdata)
    );
`else
    // No local ERROR source: holes in the map fall through to slave 0
    logic htrans_unused;

    assign HSEL_SIGNALS  = hit | NUM_SLAVES'(unmapped);
    assign def_sel       = 1'b0;
    assign ds_ready      = 1'b1;
    assign ds_resp       = HRESP_OKAY;
    assign ds_rdata      = '0;
    assign htrans_unused = ^HTRANS;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '0;
        end else if (HREADY) begin
            dsel <= {def_sel, HSEL_SIGNALS};
        end
    end

    // Response mux; with nothing selected the bus idles ready with OKAY and zero data
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                HREADY = HREADYOUT_SIGNALS[i];
                HRESP  = HRESP_SIGNALS[i];
                HRDATA = HRDATA_SIGNALS[i*DATA_W +: DATA_W];
            end
        end
        if (dsel[NUM_SLAVES]) begin
            HREADY = ds_ready;
            HRESP  = ds_resp;
            HRDATA = ds_rdata;
        end
    end

endmodule

// File: doc/ahb_decode_mux.md
AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 3, number of slave ports (legal 1..16).
REQ-002 SHALL have parameter DATA_W, default 32, HRDATA width; HADDR is fixed at 32 bits.
REQ-003 SHALL have parameter SLAVE_BASE, a packed NUM_SLAVES x 32 array, default {32'h5000_0000, 32'h4000_0000, 32'h0000_0000}, giving the region base per slave.
REQ-004 SHALL have parameter SLAVE_MASK, a packed NUM_SLAVES x 32 array, default {32'hF000_0000, 32'hF000_0000, 32'hC000_0000}, giving the compare mask per slave.
REQ-005 SHALL have these ports (name, direction, width, meaning), clock and reset first; one clock, and reset is asynchronous and active-low:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type.
- HSEL_SIGNALS  out  NUM_SLAVES  one-hot slave selects (all-zero allowed).
- HREADYOUT_SIGNALS  in  NUM_SLAVES  per-slave ready.
- HRESP_SIGNALS  in  NUM_SLAVES  per-slave response, 1 = ERROR.
- HRDATA_SIGNALS  in  NUM_SLAVES x DATA_W  per-slave read data.
- HREADY  out  1  muxed ready to master and slaves.
- HRESP  out  1  muxed response to master.
- HRDATA  out  DATA_W  muxed read data.

Function
REQ-006 Slave i SHALL match when (HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]; on overlap the lowest index SHALL win.
REQ-007 HSEL_SIGNALS SHALL be combinational from HADDR only, independent of HTRANS, with at most one bit set.
REQ-008 An address matching no slave SHALL be "unmapped", and HSEL_SIGNALS SHALL then be all-zero.
REQ-009 The data-phase select register SHALL load the address-phase decode (one-hot over NUM_SLAVES plus a default bit) on each HCLK edge where HREADY=1, and SHALL hold otherwise.
REQ-010 With slave i selected in the data phase, HREADY, HRESP and HRDATA SHALL equal HREADYOUT_SIGNALS[i], HRESP_SIGNALS[i] and HRDATA_SIGNALS[i], with zero added latency.
REQ-011 With nothing selected (after reset, or after an unmapped IDLE/BUSY transfer), the outputs SHALL be HREADY=1, HRESP=0 and HRDATA=0.
REQ-012 A default-slave FSM SHALL have the states IDLE, ERR1 and ERR2.
REQ-013 The FSM SHALL go IDLE->ERR1 when HREADY=1 and HTRANS is NONSEQ (2'b10) or SEQ (2'b11) to an unmapped address.
REQ-014 In ERR1 the outputs SHALL be HREADY=0 and HRESP=1; the FSM SHALL always advance ERR1->ERR2.
REQ-015 In ERR2 the outputs SHALL be HREADY=1 and HRESP=1; from ERR2 the FSM SHALL go to ERR1 if a new active unmapped transfer is present, else to IDLE.
REQ-016 HRDATA SHALL be 32'hDEADBEEF (zero-extended or truncated to DATA_W) during ERR1 and ERR2.
REQ-017 An unmapped IDLE/BUSY transfer SHALL get a zero-wait OKAY and SHALL NOT enter ERR1.
REQ-018 A slave that holds HREADYOUT low SHALL freeze the data-phase select and the FSM for every stalled cycle.

Reset
REQ-019 Asserting HRESETn low SHALL asynchronously clear the data-phase select to none and the FSM to IDLE, giving HREADY=1, HRESP=0 and HRDATA=0; HSEL_SIGNALS SHALL stay combinational.
REQ-020 Reset asserted during ERR1, ERR2 or a stalled slave data phase SHALL abort it with no residual state.

Configuration
REQ-021 Macro AHB_DECODE_DEFAULT_SLAVE_EN SHALL control the default slave.
- Defined: unmapped behaviour SHALL follow REQ-008 and REQ-012..REQ-017.
- Undefined: the default slave and its FSM SHALL be absent, and unmapped addresses SHALL alias to slave 0 (HSEL_SIGNALS[0]=1), so no ERROR is ever generated locally.

Structure
REQ-022 Package ahb_pkg SHALL hold:
- the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
- the HRESP encodings (OKAY, ERROR);
- the ERROR_DATA constant 32'hDEADBEEF;
- the default-slave state enum.
REQ-023 The FSM SHALL be the sub-module ahb_default_slave, instantiated only under AHB_DECODE_DEFAULT_SLAVE_EN.

Verification
REQ-024 The bench SHALL cover these scenarios (stimulus -> required response):
- Reset release, HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0, HSEL_SIGNALS=3'b001 for HADDR=0.
- NONSEQ read to 32'h4000_0010 with slave 1 returning HRDATA 32'h1234_5678 after 2 wait cycles -> HSEL_SIGNALS=3'b010, HREADY low for 2 cycles, then HRDATA=32'h1234_5678.
- Defaults with HADDR=32'h8000_0000 NONSEQ (unmapped) -> HSEL_SIGNALS=0, then ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1, HRDATA=32'hDEADBEEF).
- Back-to-back unmapped NONSEQ presented in ERR2 -> ERR1 again, with no OKAY cycle in between.
- Unmapped IDLE, then mapped NONSEQ to 32'h5000_0000 -> zero-wait OKAY, then slave 2 data phase.
- HRESETn pulsed low during ERR1 -> outputs return immediately to HREADY=1, HRESP=0, and the FSM to IDLE.
